mul8x8_rr_sched: RTL and testbench

Round-robin scheduler that shares one pipelined 8x8 unsigned multiplier between `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and tags each issued operation with the requester index. It collects the products in a result FIFO and returns them in issue order on one shared response port with backpressure. It sits between the multiply clients and the fixed-latency multiplier datapath, which has no stall input.

---
 rtl/mul_sched_pkg.sv | 24 ++
 rtl/mul8x8_rr_sched_if.sv | 24 ++
 rtl/mul8x8_pipe3.sv | 43 ++++
 rtl/mul8x8_rr_sched.sv | 102 ++++++++++
 tb/tb_mul8x8_rr_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_sched_pkg.sv
// Shared constants and payload types for the round-robin multiplier scheduler.
package mul_sched_pkg;
    localparam int unsigned NREQ        = 4;
    localparam int unsigned IDW         = $clog2(NREQ);
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned MUL_LAT     = 3;
    localparam int unsigned PIPE_STAGES = MUL_LAT + 1;
    localparam int unsigned OPW         = 8;
    localparam int unsigned PW          = 2 * OPW;
    localparam int unsigned PTRW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW        = PTRW + 1;
    localparam int unsigned INFW        = $clog2(PIPE_STAGES + 1);
    localparam int unsigned OCCW        = CNTW + 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } mul_tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  product;
    } fifo_entry_t;
endpackage

// File: rtl/mul8x8_rr_sched_if.sv
// Request/response bundle between multiply clients and the scheduler.
interface mul8x8_rr_sched_if;
    import mul_sched_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [PW-1:0]       rsp_data;
    logic                busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mul8x8_pipe3.sv
// Three-stage shift-and-add unsigned 8x8 multiplier; no stall, fixed latency.
module mul8x8_pipe3
    import mul_sched_pkg::*;
(
    input  logic           clk_mul_sched,
    input  logic           rst,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  product
);

    function automatic logic [PW-1:0] pp(input logic [OPW-1:0] x, input logic en,
                                         input int unsigned sh);
        return en ? (PW'(x) << sh) : '0;
    endfunction

    logic [PW-1:0]  acc1, acc2;
    logic [OPW-1:0] a1, a2;
    logic [4:0]     bh1;
    logic [1:0]     bh2;

    // Stage 1 sums b[2:0], stage 2 b[5:3], stage 3 b[7:6].
    always_ff @(posedge clk_mul_sched) begin
        if (rst) begin
            acc1    <= '0;
            acc2    <= '0;
            a1      <= '0;
            a2      <= '0;
            bh1     <= '0;
            bh2     <= '0;
            product <= '0;
        end else begin
            acc1    <= pp(a, b[0], 0) + pp(a, b[1], 1) + pp(a, b[2], 2);
            a1      <= a;
            bh1     <= b[7:3];
            acc2    <= acc1 + pp(a1, bh1[0], 3) + pp(a1, bh1[1], 4) + pp(a1, bh1[2], 5);
            a2      <= a1;
            bh2     <= bh1[4:3];
            product <= acc2 + pp(a2, bh2[0], 6) + pp(a2, bh2[1], 7);
        end
    end

endmodule

// File: rtl/mul8x8_rr_sched.sv
// Round-robin front end sharing one pipelined multiplier; results return in
// grant order through a FWFT FIFO that is pre-reserved at issue time.
module mul8x8_rr_sched
    import mul_sched_pkg::*;
(
    input  logic              clk_mul_sched,
    input  logic              rst,
    mul8x8_rr_sched_if.slave  bus
);

    logic [IDW-1:0]        last_gnt, win_id, arb_idx;
    logic                  win_found, issue_ok, xfer, pop, fifo_wr, rsp_vld;
    logic [INFW-1:0]       inflight;
    logic [CNTW-1:0]       fifo_cnt;
    logic [OCCW-1:0]       occ;
    logic [PTRW-1:0]       wr_ptr, rd_ptr;
    logic [OPW-1:0]        op_a, op_b, sel_a, sel_b;
    logic [OPW-1:0]        a_arr [NREQ];
    logic [OPW-1:0]        b_arr [NREQ];
    logic [PW-1:0]         product;
    mul_tag_t [PIPE_STAGES-1:0] tag_q;
    fifo_entry_t           mem [FIFO_DEPTH];
    fifo_entry_t           head;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*OPW +: OPW];
        assign b_arr[g] = bus.req_b[g*OPW +: OPW];
    end

    assign rsp_vld  = (fifo_cnt != '0) & ~rst;
    assign pop      = rsp_vld & bus.rsp_ready;
    assign fifo_wr  = tag_q[PIPE_STAGES-1].vld;
    // A slot freed by this cycle's pop is usable by this cycle's issue.
    assign occ      = OCCW'(inflight) + OCCW'(fifo_cnt) - OCCW'(pop);
    assign issue_ok = occ < OCCW'(FIFO_DEPTH);
    assign xfer     = win_found & issue_ok & ~rst;
    assign sel_a    = a_arr[win_id];
    assign sel_b    = b_arr[win_id];

    // First valid requester after the last grant, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        arb_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            arb_idx = IDW'((32'(last_gnt) + k) % NREQ);
            if (!win_found && bus.req_valid[arb_idx]) begin
                win_found = 1'b1;
                win_id    = arb_idx;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[win_id] = 1'b1;
    end

    always_ff @(posedge clk_mul_sched) begin
        if (rst) begin
            last_gnt <= IDW'(NREQ - 1);
            op_a     <= '0;
            op_b     <= '0;
            tag_q    <= '0;
            inflight <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (xfer) begin
                last_gnt <= win_id;
                op_a     <= sel_a;
                op_b     <= sel_b;
            end
            tag_q    <= {tag_q[PIPE_STAGES-2:0], mul_tag_t'{vld: xfer, id: win_id}};
            inflight <= inflight + INFW'(xfer) - INFW'(fifo_wr);
            fifo_cnt <= fifo_cnt + CNTW'(fifo_wr) - CNTW'(pop);
            if (fifo_wr) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)     rd_ptr <= rd_ptr + PTRW'(1);
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk_mul_sched) begin
        if (fifo_wr) mem[wr_ptr] <= '{id: tag_q[PIPE_STAGES-1].id, product: product};
    end

    assign head          = mem[rd_ptr];
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_id    = rsp_vld ? head.id : '0;
    assign bus.rsp_data  = rsp_vld ? head.product : '0;
    assign bus.busy      = ~rst & ((inflight != '0) | (fifo_cnt != '0));

    mul8x8_pipe3 u_mul (
        .clk_mul_sched (clk_mul_sched),
        .rst           (rst),
        .a             (op_a),
        .b             (op_b),
        .product       (product)
    );

endmodule

// File: tb/tb_mul8x8_rr_sched.sv
// Directed and random bench for mul8x8_rr_sched against a queue-based reference.
module tb_mul8x8_rr_sched;
    import mul_sched_pkg::*;

    logic clk_mul_sched = 1'b0;
    logic rst;

    mul8x8_rr_sched_if bus ();

    mul8x8_rr_sched dut (
        .clk_mul_sched (clk_mul_sched),
        .rst           (rst),
        .bus           (bus)
    );

    always #5 clk_mul_sched = ~clk_mul_sched;

    typedef struct { int id; int prod; int due; } op_t;
    typedef struct { int id; int data; } rsp_t;

    op_t  pend[$];
    op_t  resq[$];
    rsp_t pop_log[$];
    int   gnt_log[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_last = NREQ - 1;
    int acc_cnt;
    logic [NREQ-1:0] obs_ready = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the reference at the rising edge.
    task automatic cycle();
        int occ, m_w, m_a, m_b, exp_id, exp_data;
        bit m_found, m_pop, m_xfer, exp_v;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk_mul_sched);
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            resq.push_back(pend[0]);
            pend.delete(0);
        end
        occ     = pend.size() + resq.size();
        exp_v   = !rst && resq.size() > 0;
        m_pop   = exp_v && bus.rsp_ready;
        m_found = 1'b0;
        m_w     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (m_last + k) % NREQ;
            if (!m_found && bus.req_valid[idx]) begin
                m_found = 1'b1;
                m_w     = idx;
            end
        end
        m_xfer  = !rst && m_found && ((occ - int'(m_pop)) < int'(FIFO_DEPTH));
        exp_rdy = '0;
        if (m_xfer) exp_rdy[m_w] = 1'b1;
        exp_id   = 0;
        exp_data = 0;
        if (exp_v) begin
            exp_id   = resq[0].id;
            exp_data = resq[0].prod;
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("req_ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        check("busy", 32'(bus.busy), 32'(!rst && occ != 0));
        obs_ready = bus.req_ready;
        if (bus.req_ready != '0) gnt_log.push_back($clog2(bus.req_ready));
        if (bus.rsp_valid && bus.rsp_ready)
            pop_log.push_back('{int'(bus.rsp_id), int'(bus.rsp_data)});
        m_a = int'(bus.req_a[m_w*8 +: 8]);
        m_b = int'(bus.req_b[m_w*8 +: 8]);
        @(posedge clk_mul_sched);
        cyc++;
        if (rst) begin
            pend.delete();
            resq.delete();
            m_last = NREQ - 1;
        end else begin
            if (m_pop) resq.delete(0);
            if (m_xfer) begin
                pend.push_back('{m_w, m_a * m_b, cyc + 4});
                m_last = m_w;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [7:0]  xa [3];
        logic [7:0]  xb [3];
        logic [15:0] xp [3];
        int ra [NREQ];
        int rb [NREQ];
        xa = '{8'hFF, 8'h00, 8'h80};
        xb = '{8'hFF, 8'hAB, 8'h02};
        xp = '{16'hFE01, 16'h0000, 16'h0100};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);

        // Single issue from requester 2
        bus.req_valid      = 4'b0100;
        bus.req_a[23:16]   = 8'h0F;
        bus.req_b[23:16]   = 8'h11;
        cycle();
        check("single_grant", 32'(obs_ready), 32'h4);
        bus.req_valid = '0;
        idle(3);
        check("single_not_yet", 32'(bus.rsp_valid), 32'd0);
        cycle();
        check("single_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_id", 32'(bus.rsp_id), 32'd2);
        check("single_data", 32'(bus.rsp_data), 32'h00FF);
        bus.rsp_ready = 1'b1;
        cycle();
        check("single_busy_clear", 32'(bus.busy), 32'd0);

        // Extreme operands from a lone requester 1, back to back
        pop_log.delete();
        bus.req_valid = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            bus.req_a[15:8] = xa[j];
            bus.req_b[15:8] = xb[j];
            cycle();
            check("lone_grant", 32'(obs_ready), 32'h2);
        end
        bus.req_valid = '0;
        idle(8);
        check("extreme_count", 32'(pop_log.size()), 32'd3);
        for (int j = 0; j < 3 && j < pop_log.size(); j++)
            check("extreme_product", 32'(pop_log[j].data), 32'(xp[j]));

        // Round-robin fairness from reset with all requesters valid
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 16 * i + 5;
            rb[i] = 200 - 7 * i;
            bus.req_a[i*8 +: 8] = 8'(ra[i]);
            bus.req_b[i*8 +: 8] = 8'(rb[i]);
        end
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        gnt_log.delete();
        pop_log.delete();
        idle(16);
        bus.req_valid = '0;
        idle(8);
        check("rr_grant_count", 32'(gnt_log.size()), 32'd16);
        check("rr_resp_count", 32'(pop_log.size()), 32'd16);
        for (int k = 0; k < 16 && k < gnt_log.size(); k++)
            check("rr_grant_order", 32'(gnt_log[k]), 32'(k % NREQ));
        for (int k = 0; k < 16 && k < pop_log.size(); k++) begin
            check("rr_resp_id", 32'(pop_log[k].id), 32'(k % NREQ));
            check("rr_resp_data", 32'(pop_log[k].data), 32'(ra[k % NREQ] * rb[k % NREQ]));
        end

        // Backpressure: requester 0 streams into a stalled consumer
        gnt_log.delete();
        pop_log.delete();
        acc_cnt       = 0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (obs_ready[0]) begin
                acc_cnt++;
                bus.req_a[7:0] = 8'($urandom);
                bus.req_b[7:0] = 8'($urandom);
            end
        end
        check("bp_accepts", 32'(acc_cnt), 32'd8);
        check("bp_ready_low", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        cycle();
        check("bp_resume_with_pop", 32'(obs_ready), 32'h1);
        for (int n = 0; n < 13; n++) begin
            if (obs_ready[0]) begin
                bus.req_a[7:0] = 8'($urandom);
                bus.req_b[7:0] = 8'($urandom);
            end
            cycle();
        end
        bus.req_valid = '0;
        idle(16);
        check("bp_resp_count", 32'(pop_log.size()), 32'd22);

        // Reset with three in flight and two queued
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        for (int n = 0; n < 5; n++) begin
            cycle();
            bus.req_a[31:24] = 8'($urandom);
            bus.req_b[31:24] = 8'($urandom);
        end
        bus.req_valid = '0;
        cycle();
        check("mid_queued_valid", 32'(bus.rsp_valid), 32'd1);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        cycle();
        check("mid_rst_ready", 32'(obs_ready), 32'd0);
        rst = 1'b0;
        check("mid_after_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_after_busy", 32'(bus.busy), 32'd0);
        check("mid_after_id", 32'(bus.rsp_id), 32'd0);
        pop_log.delete();
        cycle();
        check("mid_next_grant", 32'(obs_ready), 32'h1);
        bus.req_valid = '0;
        idle(10);
        check("mid_resp_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) check("mid_resp_id", 32'(pop_log[0].id), 32'd0);

        // Random soak; a waiting requester keeps its operands until accepted
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || obs_ready[i]) begin
                    bus.req_valid[i]    = ($urandom_range(0, 99) < 50);
                    bus.req_a[i*8 +: 8] = 8'($urandom);
                    bus.req_b[i*8 +: 8] = 8'($urandom);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 99) < 65);
            cycle();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        idle(20);
        check("soak_drained", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
